multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV64 core. Sequences one shared memory port, the register
//  file, the ALU and the immediate generator through FETCH/DECODE/EXEC/MEM/WB.
//  Supports load (0000011), store (0100011), R-ALU (0110011), I-ALU (0010011), BEQ/BNE (1100011).
//  Raises sticky traps on illegal opcodes and on memory timeout. Counts retired instructions.
// PARAMETERS
//  TIMEOUT  255  max cycles a mem_req may stay unacknowledged before bus-error trap (1..2^CNT_W-1)
//  CNT_W    8    width of wait counter
// PORTS
//  clk        in   1   core clock
//  reset      in   1   asynchronous, active-high reset
//  opcode     in   7   inst[6:0] from IR
//  funct3     in   3   inst[14:12] from IR
//  zero       in   1   ALU zero flag (combinational, valid in BRANCH)
//  mem_ready  in   1   memory accepts/returns this cycle
//  mem_req    out  1   memory request valid
//  mem_we     out  1   1 = write (store)
//  iord       out  1   address mux: 0 = PC, 1 = ALUOut
//  ir_we      out  1   latch instruction register and oldPC
//  pc_we      out  1   write PC from ALU result
//  reg_we     out  1   register-file write enable
//  alu_src_a  out  2   0 = PC, 1 = oldPC, 2 = rs1
//  alu_src_b  out  2   0 = rs2, 1 = const 4, 2 = imm
//  alu_op     out  2   0 = add, 1 = sub, 2 = decode funct fields
//  result_src out  2   0 = ALUOut, 1 = mem rdata, 2 = ALU result
//  illegal    out  1   sticky: illegal opcode/funct3 trap
//  bus_err    out  1   sticky: memory timeout trap
//  instret    out  64  retired-instruction count
//  state_o    out  4   current state encoding (debug)
// BEHAVIOUR
//  Clocking and reset
//  - reset asserted: state = BOOT, wait counter = 0, instret = 0, illegal = bus_err = 0.
//  - In BOOT all outputs are 0. BOOT goes to FETCH unconditionally on the next edge.
//  - Reset mid-operation aborts immediately: no enable is held and no memory write completes.
//  Output timing
//  - Outputs are Moore functions of state. Exception: ir_we and pc_we in FETCH are qualified
//    by mem_ready.
//  States and transitions
//  - FETCH: mem_req=1, iord=0, src_a=0, src_b=1, alu_op=0, result_src=2.
//    Hold until mem_ready. On mem_ready: ir_we=1, pc_we=1 (PC+4) -> DECODE.
//  - DECODE: src_a=1, src_b=2, alu_op=0 (branch target into ALUOut).
//    Next state by opcode: load/store -> MEMADR; R -> EXEC_R; I -> EXEC_I;
//    branch with funct3 000/001 -> BRANCH; anything else -> TRAP with illegal set.
//  - MEMADR: src_a=2, src_b=2, alu_op=0. Load -> MEMRD; store -> MEMWR.
//  - MEMRD: mem_req=1, iord=1. Hold until mem_ready, then -> MEMWB.
//  - MEMWB: result_src=1, reg_we=1 -> FETCH (retire).
//  - MEMWR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready, then -> FETCH (retire).
//  - EXEC_R: src_a=2, src_b=0, alu_op=2 -> ALUWB.
//  - EXEC_I: src_a=2, src_b=2, alu_op=2 -> ALUWB.
//  - ALUWB: result_src=0, reg_we=1 -> FETCH (retire).
//  - BRANCH: src_a=2, src_b=0, alu_op=1, result_src=0.
//    pc_we = (funct3==000) ? zero : ~zero. Always -> FETCH (retire).
//  - TRAP: all enables 0, mem_req=0. Remains in TRAP until reset.
//  Memory handshake
//  - mem_req, mem_we and iord stay stable while waiting. Transfer occurs on the cycle with
//    mem_req & mem_ready.
//  - Wait counter clears on entry to each request state and increments per unacked cycle.
//  - If count reaches TIMEOUT with mem_ready still 0: -> TRAP, bus_err=1, no enables that cycle.
//  - mem_ready in the same cycle count reaches TIMEOUT: the transfer wins (no trap).
//  Retire counting
//  - instret increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
//  - 64-bit count wraps silently at 2^64-1 -> 0.
//  Latency (zero-wait memory)
//  - R/I: 4 cycles. Branch: 3. Store: 4. Load: 5.
// STRUCTURE
//  - Shared package riscv_pkg: opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH),
//    state encodings, and ALU-src/alu_op/result_src encodings. Shared with the datapath and
//    immgen users.
//  - One sub-module mem_wait_timer: counter, clear/enable inputs, timeout output; params
//    TIMEOUT and CNT_W.
//  - Remainder: state register, next-state logic, output decode, instret register.
// TESTING
//  1. Reset, then addi (opcode 0010011), mem_ready tied 1: states BOOT,FETCH,DECODE,EXEC_I,
//     ALUWB,FETCH; reg_we=1 in ALUWB only; instret=1.
//  2. Load with mem_ready low 3 cycles in MEMRD: mem_req and iord stable 4 cycles; reg_we with
//     result_src=1 the cycle after the ack; instret increments once.
//  3. BEQ zero=1 -> pc_we=1 in BRANCH. BNE zero=1 -> pc_we=0. funct3=100 -> TRAP, illegal=1,
//     outputs stay 0 for 20 cycles.
//  4. TIMEOUT=4, fetch never acked: TRAP after 4 waiting cycles, bus_err=1, mem_req=0.
//     Ack on the 4th cycle: no trap.
//  5. Store, reset asserted during MEMWR before mem_ready: all outputs 0 immediately,
//     instret=0, BOOT then FETCH.
//  6. 10 back-to-back R-type with zero-wait memory: instret=10 after exactly 40 cycles
//     from the first FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV64 core: opcode values, control
// FSM state encodings, datapath mux/ALU select encodings and a packed bundle
// of the controller's enables and selects.
// No ports (package).
package riscv_pkg;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Branch funct3 values the core implements
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        S_BOOT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_TRAP   = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'd0,
        SRC_A_OLDPC = 2'd1,
        SRC_A_RS1   = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_FOUR = 2'd1,
        SRC_B_IMM  = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_MEM    = 2'd1,
        RES_ALU    = 2'd2
    } result_src_e;

    // Everything the controller drives besides the sticky flags and counters
    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        ir_we;
        logic        pc_we;
        logic        reg_we;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        result_src_e result_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        mem_req: 1'b0, mem_we: 1'b0, iord: 1'b0, ir_we: 1'b0, pc_we: 1'b0, reg_we: 1'b0,
        alu_src_a: SRC_A_PC, alu_src_b: SRC_B_RS2, alu_op: ALU_ADD, result_src: RES_ALUOUT
    };

    // States that hold mem_req high and wait on mem_ready
    function automatic logic is_req_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the control FSM and the memory.
//  mem_req    request valid (held stable until mem_ready)
//  mem_we     1 = write (store)
//  iord       address mux select: 0 = PC, 1 = ALUOut
//  mem_ready  memory accepts/returns data this cycle
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged cycles of a memory request and flags the cycle on
// which the TIMEOUT-th unacknowledged cycle is in progress.
//  clk, reset  core clock, asynchronous active-high reset
//  clr         zero the counter (takes priority over en)
//  en          one more unacknowledged cycle
//  expired     this is the TIMEOUT-th consecutive waiting cycle
module mem_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

    // count holds the number of waiting cycles already completed, so it equals
    // TIMEOUT-1 during the TIMEOUT-th one.
    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV64 core. Sequences the shared memory
// port, register file, ALU and immediate generator through
// FETCH/DECODE/EXEC/MEM/WB, raises sticky illegal/bus-error traps and counts
// retired instructions.
//  clk, reset     core clock, asynchronous active-high reset
//  opcode,funct3  instruction fields from IR
//  zero           ALU zero flag (used in BRANCH)
//  mem            memory handshake (master side)
//  ir_we, pc_we, reg_we               register enables
//  alu_src_a, alu_src_b, alu_op, result_src  datapath selects
//  illegal, bus_err  sticky trap flags
//  instret        64-bit retired-instruction count
//  state_o        current state encoding (debug)
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     zero,
    multicycle_ctrl_if.master        mem,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic                     reg_we,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic [1:0]               result_src,
    output logic                     illegal,
    output logic                     bus_err,
    output logic [63:0]              instret,
    output logic [3:0]               state_o
);

    state_e state, state_next;
    ctrl_t  ctrl;
    logic   retire;
    logic   set_illegal;
    logic   set_bus_err;
    logic   wait_expired;
    logic   waiting;

    // Memory has not answered an outstanding request this cycle
    assign waiting = is_req_state(state) && !mem.mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_next != state),   // any state change rearms the timer
        .en      (waiting),
        .expired (wait_expired)
    );

    // NOTE: only control registers are reset; there is no memory array here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_BOOT;
            instret <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= state_next;
            if (retire)      instret <= instret + 64'd1;
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        ctrl        = CTRL_IDLE;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;

        unique case (state)
            S_BOOT: state_next = S_FETCH;

            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRC_A_PC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
                if (mem.mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    ctrl.pc_we = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_DECODE: begin
                // Branch target (oldPC + imm) is computed here into ALUOut
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                if (opcode == OP_LOAD || opcode == OP_STORE)
                    state_next = S_MEMADR;
                else if (opcode == OP_R)
                    state_next = S_EXEC_R;
                else if (opcode == OP_I)
                    state_next = S_EXEC_I;
                else if (opcode == OP_BRANCH && (funct3 == F3_BEQ || funct3 == F3_BNE))
                    state_next = S_BRANCH;
                else begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_MEMADR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_next     = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem.mem_ready)
                    state_next = S_MEMWB;
                else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_we     = 1'b1;
                retire          = 1'b1;
                state_next      = S_FETCH;
            end

            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem.mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = S_ALUWB;
            end

            S_EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = S_ALUWB;
            end

            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_we     = 1'b1;
                retire          = 1'b1;
                state_next      = S_FETCH;
            end

            S_BRANCH: begin
                // rs1 - rs2 sets zero; ALUOut already holds the target
                ctrl.alu_src_a  = SRC_A_RS1;
                ctrl.alu_src_b  = SRC_B_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_we      = (funct3 == F3_BEQ) ? zero : ~zero;
                retire          = 1'b1;
                state_next      = S_FETCH;
            end

            S_TRAP: state_next = S_TRAP;

            default: state_next = S_BOOT;
        endcase
    end

    assign mem.mem_req = ctrl.mem_req;
    assign mem.mem_we  = ctrl.mem_we;
    assign mem.iord    = ctrl.iord;
    assign ir_we       = ctrl.ir_we;
    assign pc_we       = ctrl.pc_we;
    assign reg_we      = ctrl.reg_we;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign result_src  = ctrl.result_src;
    assign state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. The DUT is built with TIMEOUT=4 so
// the bus-error trap and its ack-on-last-cycle boundary can be exercised in a
// handful of cycles. Inputs change and outputs are sampled 1 ns after the
// rising edge.
module tb_multicycle_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        ir_we, pc_we, reg_we;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic        illegal, bus_err;
    logic [63:0] instret;
    logic [3:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem        (bus.master),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .instret    (instret),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Expected output vectors:
    // {mem_req, mem_we, iord, ir_we, pc_we, reg_we, src_a, src_b, alu_op, result_src}
    localparam logic [13:0] O_IDLE       = 14'b0;
    localparam logic [13:0] O_FETCH_ACK  = {6'b100110, 2'd0, 2'd1, 2'd0, 2'd2};
    localparam logic [13:0] O_FETCH_WAIT = {6'b100000, 2'd0, 2'd1, 2'd0, 2'd2};
    localparam logic [13:0] O_DECODE     = {6'b000000, 2'd1, 2'd2, 2'd0, 2'd0};
    localparam logic [13:0] O_EXEC_I     = {6'b000000, 2'd2, 2'd2, 2'd2, 2'd0};
    localparam logic [13:0] O_EXEC_R     = {6'b000000, 2'd2, 2'd0, 2'd2, 2'd0};
    localparam logic [13:0] O_ALUWB      = {6'b000001, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [13:0] O_MEMADR     = {6'b000000, 2'd2, 2'd2, 2'd0, 2'd0};
    localparam logic [13:0] O_MEMRD      = {6'b101000, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [13:0] O_MEMWB      = {6'b000001, 2'd0, 2'd0, 2'd0, 2'd1};
    localparam logic [13:0] O_MEMWR      = {6'b111000, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [13:0] O_BR_TAKEN   = {6'b000010, 2'd2, 2'd0, 2'd1, 2'd0};
    localparam logic [13:0] O_BR_NOT     = {6'b000000, 2'd2, 2'd0, 2'd1, 2'd0};

    function automatic logic [13:0] outs();
        return {bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, reg_we,
                alu_src_a, alu_src_b, alu_op, result_src};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        opcode = 7'b0;
        funct3 = 3'b0;
        zero   = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (state_o !== S_BOOT) begin
            n_fail++; $display("FAIL reset state: got %0d expected %0d", state_o, S_BOOT);
        end
        n_checks++;
        if (outs() !== O_IDLE) begin
            n_fail++; $display("FAIL reset outputs: got %h expected %h", outs(), O_IDLE);
        end
        n_checks++;
        if ({illegal, bus_err, instret} !== 66'b0) begin
            n_fail++; $display("FAIL reset flags/instret: got %b %b %0d expected 0 0 0", illegal, bus_err, instret);
        end
    endtask

    task automatic test_alu_i();
        state_e exp_s [5]     = '{S_FETCH, S_DECODE, S_EXEC_I, S_ALUWB, S_FETCH};
        logic [13:0] exp_o [4] = '{O_FETCH_ACK, O_DECODE, O_EXEC_I, O_ALUWB};
        do_reset();
        bus.mem_ready = 1'b1;
        opcode = OP_I;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (state_o !== exp_s[i]) begin
                n_fail++; $display("FAIL addi state step %0d: got %0d expected %0d", i, state_o, exp_s[i]);
            end
            if (i < 4) begin
                n_checks++;
                if (outs() !== exp_o[i]) begin
                    n_fail++; $display("FAIL addi outputs step %0d: got %h expected %h", i, outs(), exp_o[i]);
                end
            end
        end
        n_checks++;
        if (instret !== 64'd1) begin
            n_fail++; $display("FAIL addi instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        bus.mem_ready = 1'b1;
        opcode = OP_LOAD;
        cyc();  // FETCH
        cyc();  // DECODE
        cyc();  // MEMADR
        n_checks++;
        if (outs() !== O_MEMADR) begin
            n_fail++; $display("FAIL load memadr outputs: got %h expected %h", outs(), O_MEMADR);
        end
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) bus.mem_ready = 1'b1;  // ack on the 4th MEMRD cycle
            n_checks++;
            if (state_o !== S_MEMRD || outs() !== O_MEMRD) begin
                n_fail++; $display("FAIL load memrd cycle %0d: got state %0d out %h expected state %0d out %h",
                                   i, state_o, outs(), S_MEMRD, O_MEMRD);
            end
        end
        cyc();
        n_checks++;
        if (state_o !== S_MEMWB || outs() !== O_MEMWB || instret !== 64'd0) begin
            n_fail++; $display("FAIL load memwb: got state %0d out %h instret %0d expected state %0d out %h instret 0",
                               state_o, outs(), instret, S_MEMWB, O_MEMWB);
        end
        cyc();
        n_checks++;
        if (state_o !== S_FETCH || instret !== 64'd1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL load retire: got state %0d instret %0d bus_err %b expected %0d 1 0",
                               state_o, instret, bus_err, S_FETCH);
        end
    endtask

    task automatic test_branch();
        do_reset();
        bus.mem_ready = 1'b1;
        opcode = OP_BRANCH;
        funct3 = 3'b000;
        zero   = 1'b1;
        cyc();  // FETCH
        cyc();  // DECODE
        cyc();  // BRANCH (beq taken)
        n_checks++;
        if (state_o !== S_BRANCH || outs() !== O_BR_TAKEN) begin
            n_fail++; $display("FAIL beq taken: got state %0d out %h expected state %0d out %h",
                               state_o, outs(), S_BRANCH, O_BR_TAKEN);
        end
        funct3 = 3'b001;  // bne, zero still 1 -> not taken
        cyc();  // FETCH
        n_checks++;
        if (instret !== 64'd1) begin
            n_fail++; $display("FAIL beq retire: got %0d expected 1", instret);
        end
        cyc();  // DECODE
        cyc();  // BRANCH
        n_checks++;
        if (outs() !== O_BR_NOT) begin
            n_fail++; $display("FAIL bne zero=1: got %h expected %h", outs(), O_BR_NOT);
        end
        zero = 1'b0;  // bne with zero=0 -> taken, same cycle
        #1;
        n_checks++;
        if (pc_we !== 1'b1) begin
            n_fail++; $display("FAIL bne zero=0 pc_we: got %b expected 1", pc_we);
        end
        funct3 = 3'b100;
        cyc();  // FETCH
        cyc();  // DECODE
        n_checks++;
        if (illegal !== 1'b0) begin
            n_fail++; $display("FAIL branch f3=100 early illegal: got %b expected 0", illegal);
        end
        cyc();  // TRAP
        n_checks++;
        if (state_o !== S_TRAP || illegal !== 1'b1 || instret !== 64'd2) begin
            n_fail++; $display("FAIL branch f3=100 trap: got state %0d illegal %b instret %0d expected %0d 1 2",
                               state_o, illegal, instret, S_TRAP);
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_checks++;
            if (state_o !== S_TRAP || outs() !== O_IDLE || illegal !== 1'b1) begin
                n_fail++; $display("FAIL trap hold cycle %0d: got state %0d out %h illegal %b expected %0d %h 1",
                                   i, state_o, outs(), illegal, S_TRAP, O_IDLE);
            end
        end
    endtask

    task automatic test_illegal_opcode();
        do_reset();
        bus.mem_ready = 1'b1;
        opcode = 7'b1111111;
        cyc();  // FETCH
        cyc();  // DECODE
        cyc();
        n_checks++;
        if (state_o !== S_TRAP || illegal !== 1'b1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL illegal opcode: got state %0d illegal %b bus_err %b expected %0d 1 0",
                               state_o, illegal, bus_err, S_TRAP);
        end
    endtask

    task automatic test_timeout();
        // Fetch never acknowledged: trap after exactly four waiting cycles
        do_reset();
        opcode = OP_R;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (state_o !== S_FETCH || outs() !== O_FETCH_WAIT || bus_err !== 1'b0) begin
                n_fail++; $display("FAIL timeout wait cycle %0d: got state %0d out %h bus_err %b expected %0d %h 0",
                                   i, state_o, outs(), bus_err, S_FETCH, O_FETCH_WAIT);
            end
        end
        cyc();
        n_checks++;
        if (state_o !== S_TRAP || bus_err !== 1'b1 || bus.mem_req !== 1'b0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL timeout trap: got state %0d bus_err %b mem_req %b illegal %b expected %0d 1 0 0",
                               state_o, bus_err, bus.mem_req, illegal, S_TRAP);
        end
        // Ack arriving on the 4th waiting cycle wins over the timeout
        do_reset();
        opcode = OP_R;
        cyc(); cyc(); cyc();
        cyc();
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (state_o !== S_FETCH || outs() !== O_FETCH_ACK) begin
            n_fail++; $display("FAIL late ack fetch: got state %0d out %h expected %0d %h",
                               state_o, outs(), S_FETCH, O_FETCH_ACK);
        end
        cyc();
        n_checks++;
        if (state_o !== S_DECODE || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL late ack no trap: got state %0d bus_err %b expected %0d 0",
                               state_o, bus_err, S_DECODE);
        end
    endtask

    task automatic test_store_reset();
        do_reset();
        bus.mem_ready = 1'b1;
        opcode = OP_I;
        cyc(); cyc(); cyc(); cyc(); cyc();  // addi retires, back in FETCH
        opcode = OP_STORE;
        cyc();  // DECODE
        cyc();  // MEMADR
        bus.mem_ready = 1'b0;
        cyc();  // MEMWR, waiting
        n_checks++;
        if (state_o !== S_MEMWR || outs() !== O_MEMWR || instret !== 64'd1) begin
            n_fail++; $display("FAIL store memwr: got state %0d out %h instret %0d expected %0d %h 1",
                               state_o, outs(), instret, S_MEMWR, O_MEMWR);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (state_o !== S_BOOT || outs() !== O_IDLE || instret !== 64'd0) begin
            n_fail++; $display("FAIL async reset in memwr: got state %0d out %h instret %0d expected %0d %h 0",
                               state_o, outs(), instret, S_BOOT, O_IDLE);
        end
        cyc();
        reset = 1'b0;
        n_checks++;
        if (state_o !== S_BOOT) begin
            n_fail++; $display("FAIL reset held state: got %0d expected %0d", state_o, S_BOOT);
        end
        cyc();
        n_checks++;
        if (state_o !== S_FETCH || instret !== 64'd0) begin
            n_fail++; $display("FAIL after reset release: got state %0d instret %0d expected %0d 0",
                               state_o, instret, S_FETCH);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.mem_ready = 1'b1;
        opcode = OP_R;
        cyc();  // first FETCH
        n_checks++;
        if (state_o !== S_FETCH) begin
            n_fail++; $display("FAIL b2b first fetch: got %0d expected %0d", state_o, S_FETCH);
        end
        cyc(); cyc();
        n_checks++;
        if (outs() !== O_EXEC_R) begin
            n_fail++; $display("FAIL b2b exec_r outputs: got %h expected %h", outs(), O_EXEC_R);
        end
        for (int i = 2; i < 39; i++) cyc();
        n_checks++;
        if (instret !== 64'd9 || state_o !== S_ALUWB) begin
            n_fail++; $display("FAIL b2b cycle 39: got instret %0d state %0d expected 9 %0d",
                               instret, state_o, S_ALUWB);
        end
        cyc();
        n_checks++;
        if (instret !== 64'd10 || state_o !== S_FETCH) begin
            n_fail++; $display("FAIL b2b cycle 40: got instret %0d state %0d expected 10 %0d",
                               instret, state_o, S_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_alu_i();
        test_load_wait();
        test_branch();
        test_illegal_opcode();
        test_timeout();
        test_store_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
